uart_rx: RTL and testbench

Receives 8N1 asynchronous serial frames on the 50 MHz clock domain and delivers each byte over a single-entry valid/ready output buffer. It does its own 16x oversampling, dividing `clk50` down to a sample tick, and centres its samples on each bit. It sits beside the transmit-side baud logic in the monitor FPGA, between the external RX pin and the command/data consumer. Framing errors and overruns are reported as single-cycle pulses.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_if.sv | 14 +
 rtl/uart_tick_gen.sv | 43 ++++
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive/transmit slice.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int DATA_BITS = 8;

    // Rounded clk_hz / (baud * os), i.e. clocks per oversample tick.
    function automatic int tick_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte delivery bus of the receiver: valid/ready buffer plus error pulses.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 frame_err;
    logic                 overrun;

    modport master (output data, output valid, output frame_err, output overrun, input ready);
    modport slave  (input data, input valid, input frame_err, input overrun, output ready);

endinterface

// File: rtl/uart_tick_gen.sv
// Oversample tick divider; clear restarts the count so ticks align to a frame edge.
module uart_tick_gen #(
    parameter int TICK_DIV = 27
) (
    input  logic clk50,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_tick;

    // Next count: clear wins, otherwise wrap at LAST.
    always_comb begin
        w_cnt_next = r_cnt;
        if (clear) begin
            w_cnt_next = '0;
        end else if (r_cnt == LAST) begin
            w_cnt_next = '0;
        end else begin
            w_cnt_next = r_cnt + CW'(1);
        end
    end

    // Counter and registered tick, high while the count sits at LAST.
    always_ff @(posedge clk50) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_tick <= (w_cnt_next == LAST);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver: 16x oversampling, mid-bit sampling, single-entry output buffer.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk50,
    input  logic      reset,
    input  logic      rx,
    output logic      busy,
    uart_rx_if.master bus
);

    localparam int TICK_DIV = tick_div(CLK_HZ, BAUD_RATE, OVERSAMPLE);

    logic                 r_sync1, r_sync2, r_rx_prev;
    logic                 w_fall, w_tick, w_tick_clr;
    rx_state_t            r_state, w_state_next;
    logic [3:0]           r_samp, w_samp_next;
    logic [2:0]           r_bit_idx, w_bit_idx_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic [DATA_BITS-1:0] r_data, w_data_next;
    logic                 r_valid, w_valid_next;
    logic                 r_frame_err, w_frame_err_next;
    logic                 r_overrun, w_overrun_next;
    logic                 r_busy;

    uart_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk50 (clk50),
        .reset (reset),
        .clear (w_tick_clr),
        .tick  (w_tick)
    );

    // Two-flop synchronizer plus edge register; all idle high.
    always_ff @(posedge clk50) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_fall = r_rx_prev & ~r_sync2;

    // Next-state, datapath and output-buffer logic.
    always_comb begin
        w_state_next     = r_state;
        w_samp_next      = r_samp;
        w_bit_idx_next   = r_bit_idx;
        w_shift_next     = r_shift;
        w_data_next      = r_data;
        w_frame_err_next = 1'b0;
        w_overrun_next   = 1'b0;
        w_tick_clr       = 1'b0;
        if (r_valid && bus.ready) begin
            w_valid_next = 1'b0;
        end else begin
            w_valid_next = r_valid;
        end
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_tick_clr     = 1'b1;
                    w_samp_next    = 4'd0;
                    w_bit_idx_next = 3'd0;
                    w_state_next   = START;
                end else begin
                    w_state_next = IDLE;
                end
            end
            START: begin
                if (w_tick && (r_samp == 4'd7)) begin
                    w_samp_next  = 4'd0;
                    w_state_next = r_sync2 ? IDLE : DATA;
                end else if (w_tick) begin
                    w_samp_next = r_samp + 4'd1;
                end else begin
                    w_samp_next = r_samp;
                end
            end
            DATA: begin
                if (w_tick && (r_samp == 4'd15)) begin
                    w_samp_next  = 4'd0;
                    w_shift_next = {r_sync2, r_shift[DATA_BITS-1:1]};
                    if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                        w_bit_idx_next = 3'd0;
                        w_state_next   = STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else if (w_tick) begin
                    w_samp_next = r_samp + 4'd1;
                end else begin
                    w_samp_next = r_samp;
                end
            end
            STOP: begin
                if (w_tick && (r_samp == 4'd15)) begin
                    w_samp_next = 4'd0;
                    if (!r_sync2) begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = BREAK;
                    end else if (!r_valid || bus.ready) begin
                        // A same-cycle handshake frees the buffer, so the load wins.
                        w_data_next  = r_shift;
                        w_valid_next = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_overrun_next = 1'b1;
                        w_state_next   = IDLE;
                    end
                end else if (w_tick) begin
                    w_samp_next = r_samp + 4'd1;
                end else begin
                    w_samp_next = r_samp;
                end
            end
            BREAK: begin
                if (r_sync2) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = BREAK;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk50) begin
        if (reset) begin
            r_state     <= IDLE;
            r_samp      <= 4'd0;
            r_bit_idx   <= 3'd0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_samp      <= w_samp_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_data      <= w_data_next;
            r_valid     <= w_valid_next;
            r_frame_err <= w_frame_err_next;
            r_overrun   <= w_overrun_next;
            r_busy      <= (w_state_next != IDLE);
        end
    end

    assign bus.data      = r_data;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
    assign busy          = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx; runs at 4 clocks per tick (64 clocks per bit) to keep runs short.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int  CLK_HZ = 50_000_000;
    localparam int  BAUD   = 781_250;
    localparam real BIT_NS = 1280.0;

    logic clk50 = 1'b0;
    logic reset;
    logic rx;
    logic busy;

    uart_rx_if bus ();

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(16)) dut (
        .clk50 (clk50),
        .reset (reset),
        .rx    (rx),
        .busy  (busy),
        .bus   (bus)
    );

    always #10 clk50 = ~clk50;

    int         acc_cnt   = 0;
    int         ferr_cnt  = 0;
    int         ovr_cnt   = 0;
    logic [7:0] last_data = 8'h00;

    // Consumer-side monitor: counts handshakes and error pulses.
    always @(negedge clk50) begin
        if (bus.valid && bus.ready) begin
            acc_cnt   <= acc_cnt + 1;
            last_data <= bus.data;
        end
        if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
        if (bus.overrun)   ovr_cnt  <= ovr_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk50);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input real bit_ns, input logic stop);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop;
        #(bit_ns);
    endtask

    typedef struct {
        logic [7:0] byte_v;
        int         rate;      // 0 nominal, 1 line +2 %, 2 line -2 %
        logic       stop;
        int         exp_acc;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[$];
    vec_t hv;

    function automatic real rate_ns(input int rate);
        if (rate == 1) return BIT_NS / 1.02;
        if (rate == 2) return BIT_NS / 0.98;
        return BIT_NS;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int a0;
        int f0;
        int o0;
        a0 = acc_cnt;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        send_byte(v.byte_v, rate_ns(v.rate), v.stop);
        rx = 1'b1;
        clk_wait(8);
        check({tag, " acc"}, 32'(acc_cnt - a0), 32'(v.exp_acc));
        if (v.exp_acc != 0) check({tag, " data"}, {24'h0, last_data}, {24'h0, v.exp_data});
        check({tag, " ferr"}, 32'(ferr_cnt - f0), 32'(v.exp_ferr));
        check({tag, " ovr"}, 32'(ovr_cnt - o0), 32'd0);
        check({tag, " busy"}, {31'h0, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int a0;
        int f0;
        int o0;

        vecs.push_back('{8'h55, 0, 1'b1, 1, 8'h55, 0});
        vecs.push_back('{8'hA3, 0, 1'b1, 1, 8'hA3, 0});
        vecs.push_back('{8'h81, 0, 1'b1, 1, 8'h81, 0});
        vecs.push_back('{8'hC3, 0, 1'b0, 0, 8'h00, 1});
        for (int i = 0; i < 16; i++) begin
            vecs.push_back('{8'(i * 17), 1, 1'b1, 1, 8'(i * 17), 0});
            vecs.push_back('{8'(255 - i * 17), 2, 1'b1, 1, 8'(255 - i * 17), 0});
        end

        rx        = 1'b1;
        reset     = 1'b1;
        bus.ready = 1'b1;
        clk_wait(5);
        reset = 1'b0;
        check("rst data", {24'h0, bus.data}, 32'h00);
        check("rst valid", {31'h0, bus.valid}, 32'd0);
        check("rst ferr", {31'h0, bus.frame_err}, 32'd0);
        check("rst ovr", {31'h0, bus.overrun}, 32'd0);
        check("rst busy", {31'h0, busy}, 32'd0);
        clk_wait(4);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Glitch shorter than half a bit is a false start.
        a0 = acc_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        clk_wait(10);
        check("glitch busy", {31'h0, busy}, 32'd1);
        clk_wait(10);
        rx = 1'b1;
        clk_wait(64);
        check("glitch idle", {31'h0, busy}, 32'd0);
        check("glitch acc", 32'(acc_cnt - a0), 32'd0);
        check("glitch ferr", 32'(ferr_cnt - f0), 32'd0);
        hv = '{8'hA3, 0, 1'b1, 1, 8'hA3, 0};
        run_vec(hv, "after glitch");

        // Stop bit low, then line held low: one frame_err, stays in BREAK.
        a0 = acc_cnt;
        f0 = ferr_cnt;
        send_byte(8'h3C, BIT_NS, 1'b0);
        clk_wait(128);
        check("brk ferr", 32'(ferr_cnt - f0), 32'd1);
        check("brk acc", 32'(acc_cnt - a0), 32'd0);
        check("brk valid", {31'h0, bus.valid}, 32'd0);
        check("brk busy", {31'h0, busy}, 32'd1);
        rx = 1'b1;
        clk_wait(8);
        check("brk exit", {31'h0, busy}, 32'd0);
        check("brk single", 32'(ferr_cnt - f0), 32'd1);
        hv = '{8'h81, 0, 1'b1, 1, 8'h81, 0};
        run_vec(hv, "after break");

        // Back-to-back with ready low: first byte held, second overruns.
        bus.ready = 1'b0;
        a0 = acc_cnt;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        send_byte(8'h12, BIT_NS, 1'b1);
        send_byte(8'h34, BIT_NS, 1'b1);
        clk_wait(8);
        check("ovr pulse", 32'(ovr_cnt - o0), 32'd1);
        check("ovr valid", {31'h0, bus.valid}, 32'd1);
        check("ovr data", {24'h0, bus.data}, 32'h12);
        check("ovr ferr", 32'(ferr_cnt - f0), 32'd0);
        bus.ready = 1'b1;
        clk_wait(4);
        check("ovr drain acc", 32'(acc_cnt - a0), 32'd1);
        check("ovr drain data", {24'h0, last_data}, 32'h12);
        check("ovr drain valid", {31'h0, bus.valid}, 32'd0);
        clk_wait(64);
        check("ovr only one", 32'(acc_cnt - a0), 32'd1);

        // Reset in the middle of the data bits of 0xF0, with a byte pending.
        bus.ready = 1'b0;
        send_byte(8'h55, BIT_NS, 1'b1);
        clk_wait(8);
        check("pre-rst valid", {31'h0, bus.valid}, 32'd1);
        check("pre-rst data", {24'h0, bus.data}, 32'h55);
        a0 = acc_cnt;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        fork
            send_byte(8'hF0, BIT_NS, 1'b1);
            begin
                #(BIT_NS * 6.5);
                @(posedge clk50);
                #1;
                check("mid busy", {31'h0, busy}, 32'd1);
                reset = 1'b1;
                @(posedge clk50);
                #1;
                reset = 1'b0;
                check("mid rst data", {24'h0, bus.data}, 32'h00);
                check("mid rst valid", {31'h0, bus.valid}, 32'd0);
                check("mid rst busy", {31'h0, busy}, 32'd0);
                check("mid rst ferr", {31'h0, bus.frame_err}, 32'd0);
                check("mid rst ovr", {31'h0, bus.overrun}, 32'd0);
            end
        join
        clk_wait(64);
        check("post-rst valid", {31'h0, bus.valid}, 32'd0);
        check("post-rst busy", {31'h0, busy}, 32'd0);
        check("post-rst ferr", 32'(ferr_cnt - f0), 32'd0);
        check("post-rst ovr", 32'(ovr_cnt - o0), 32'd0);
        check("post-rst acc", 32'(acc_cnt - a0), 32'd0);
        bus.ready = 1'b1;
        clk_wait(2);
        hv = '{8'h0F, 0, 1'b1, 1, 8'h0F, 0};
        run_vec(hv, "after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
